freq_meter: RTL and testbench

Measures the frequency of a slow, asynchronous square wave (for example, a divided clock from a `freq_divider`) by counting its rising edges over a fixed gate window of `clk_in` cycles. Each result is latched onto `freq_out`, and `valid` pulses for one cycle when it updates. The block is the consuming end of the divided-clock path and is used to check divider output rates on-board. With the 100 MHz system clock and the default 1 s gate, `freq_out` reads directly in Hz.

---
 rtl/freq_pkg.sv | 12 +
 rtl/sync_edge.sv | 30 +++
 rtl/freq_meter.sv | 106 ++++++++++
 tb/tb_freq_meter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency meter: FSM encoding and default clock/gate constants.
package freq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    localparam int SYS_CLK_HZ = 100_000_000;
    localparam int GATE_1S    = 100_000_000;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a history flop; flags one-cycle rising edges of an async input.
module sync_edge
    import freq_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Metastability filter (s1, s2) plus previous-sample history (s3)
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/freq_meter.sv
// Counts synchronized rising edges of sig_in over back-to-back gate windows of GATE_CYCLES clocks
// and publishes each saturated count on freq_out with a one-cycle valid pulse.
module freq_meter
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_1S,
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 27
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             ovf
);

    localparam logic [GATE_W-1:0] LAST_GATE = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t            state_r;
    logic [GATE_W-1:0] gate_cnt_r;
    logic [CNT_W-1:0]  edge_cnt_r;
    logic              sat_r;
    logic              rise_s;
    logic              last_s;
    logic [CNT_W-1:0]  edge_next_s;
    logic              sat_next_s;

    sync_edge u_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .d      (sig_in),
        .rise   (rise_s)
    );

    // Saturating next count; includes a rise landing in the current cycle
    always_comb begin
        last_s      = (gate_cnt_r == LAST_GATE);
        edge_next_s = edge_cnt_r;
        sat_next_s  = sat_r;
        if (rise_s && (edge_cnt_r == CNT_MAX)) begin
            edge_next_s = CNT_MAX;
            sat_next_s  = 1'b1;
        end else if (rise_s) begin
            edge_next_s = edge_cnt_r + CNT_W'(1'b1);
            sat_next_s  = sat_r;
        end else begin
            edge_next_s = edge_cnt_r;
            sat_next_s  = sat_r;
        end
    end

    // Gate FSM, counters and registered result outputs
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_r    <= IDLE;
            gate_cnt_r <= {GATE_W{1'b0}};
            edge_cnt_r <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
            freq_out   <= {CNT_W{1'b0}};
            valid      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    gate_cnt_r <= {GATE_W{1'b0}};
                    edge_cnt_r <= {CNT_W{1'b0}};
                    sat_r      <= 1'b0;
                    state_r    <= en ? GATE : IDLE;
                end
                GATE: begin
                    // Closing cycle wins over abort so the result is still delivered when en drops here
                    if (last_s) begin
                        freq_out   <= edge_next_s;
                        ovf        <= sat_next_s;
                        valid      <= 1'b1;
                        gate_cnt_r <= {GATE_W{1'b0}};
                        edge_cnt_r <= {CNT_W{1'b0}};
                        sat_r      <= 1'b0;
                        state_r    <= en ? GATE : IDLE;
                    end else if (!en) begin
                        gate_cnt_r <= {GATE_W{1'b0}};
                        edge_cnt_r <= {CNT_W{1'b0}};
                        sat_r      <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        gate_cnt_r <= gate_cnt_r + GATE_W'(1'b1);
                        edge_cnt_r <= edge_next_s;
                        sat_r      <= sat_next_s;
                        state_r    <= GATE;
                    end
                end
                default: begin
                    gate_cnt_r <= {GATE_W{1'b0}};
                    edge_cnt_r <= {CNT_W{1'b0}};
                    sat_r      <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (8-bit and 4-bit counters, 100-cycle gate) with a result scoreboard.
module tb_freq_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en8, en4;
    logic       sig8, sig4;
    logic [7:0] freq8;
    logic [3:0] freq4;
    logic       valid8, valid4, ovf8, ovf4;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .GATE_W(7)) dut8 (
        .clk_in(clk), .reset(reset), .en(en8), .sig_in(sig8),
        .freq_out(freq8), .valid(valid8), .ovf(ovf8)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .GATE_W(7)) dut4 (
        .clk_in(clk), .reset(reset), .en(en4), .sig_in(sig4),
        .freq_out(freq4), .valid(valid4), .ovf(ovf4)
    );

    typedef struct {
        int freq;
        bit ovf;
        int tol;
        int gap;
    } exp_t;

    typedef struct {
        bit sel4;
        bit start;
        int half;
        int exp_freq;
        bit exp_ovf;
        int tol;
        int gap;
    } vec_t;

    exp_t q8[$];
    exp_t q4[$];
    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ref8 = 0, ref4 = 0;
    int half8 = 0, half4 = 0, ph8 = 0, ph4 = 0;

    task automatic cmp(input string name, input int act, input int exp, input int tol);
        int d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    task automatic push(input bit sel4, input int f, input bit o, input int tol, input int gap);
        exp_t e;
        e.freq = f; e.ovf = o; e.tol = tol; e.gap = gap;
        if (sel4) q4.push_back(e);
        else q8.push_back(e);
    endtask

    task automatic check_valid(input bit sel4, input int f_act, input bit o_act);
        exp_t e;
        int gap_act;
        gap_act = sel4 ? (cyc - ref4) : (cyc - ref8);
        if (sel4) ref4 = cyc;
        else ref8 = cyc;
        if ((sel4 && q4.size() == 0) || (!sel4 && q8.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid dut%0d: freq %0d with no result pending at cycle %0d",
                     sel4 ? 4 : 8, f_act, cyc);
        end else begin
            e = sel4 ? q4.pop_front() : q8.pop_front();
            cmp(sel4 ? "freq4" : "freq8", f_act, e.freq, e.tol);
            cmp(sel4 ? "ovf4" : "ovf8", int'(o_act), int'(e.ovf), 0);
            if (e.gap != 0) cmp(sel4 ? "gap4" : "gap8", gap_act, e.gap, 0);
        end
    endtask

    // One clock: sample outputs at the falling edge, then advance the square-wave generators.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (valid8) check_valid(1'b0, int'(freq8), ovf8);
        if (valid4) check_valid(1'b1, int'(freq4), ovf4);
        if (half8 > 0) begin
            ph8++;
            if (ph8 >= half8) begin sig8 = ~sig8; ph8 = 0; end
        end
        if (half4 > 0) begin
            ph4++;
            if (ph4 >= half4) begin sig4 = ~sig4; ph4 = 0; end
        end
    endtask

    task automatic wait_empty(input bit sel4, input int budget);
        int n;
        n = 0;
        while (((sel4 && q4.size() > 0) || (!sel4 && q8.size() > 0)) && n < budget) begin
            step();
            n++;
        end
        cmp(sel4 ? "pending4" : "pending8", sel4 ? q4.size() : q8.size(), 0, 0);
        if (sel4) q4.delete();
        else q8.delete();
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_freq8"}, int'(freq8), 0, 0);
        cmp({tag, "_valid8"}, int'(valid8), 0, 0);
        cmp({tag, "_ovf8"}, int'(ovf8), 0, 0);
    endtask

    initial begin
        //         sel4  start half freq ovf  tol gap
        vecs[0] = '{1'b0, 1'b0, 5,  10, 1'b0, 1, 101};
        vecs[1] = '{1'b0, 1'b0, 5,  10, 1'b0, 0, 100};
        vecs[2] = '{1'b0, 1'b0, 5,  10, 1'b0, 0, 100};
        vecs[3] = '{1'b1, 1'b1, 2,  15, 1'b1, 0, 101};
        vecs[4] = '{1'b1, 1'b0, 10, 5,  1'b0, 1, 100};
        vecs[5] = '{1'b1, 1'b0, 10, 5,  1'b0, 0, 100};

        reset = 1'b0; en8 = 1'b1; en4 = 1'b0; sig8 = 1'b0; sig4 = 1'b0;
        half8 = 5; half4 = 0;

        // Reset held with en high and sig toggling: outputs stay zero
        for (int i = 0; i < 5; i++) begin
            step();
            check_zero("reset");
        end
        reset = 1'b1;
        ref8 = cyc;

        // Table of continuous windows (dut8 period 10, then dut4 saturation and recovery)
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].start) begin
                en8 = 1'b0; en4 = 1'b0;
                if (vecs[i].sel4) begin half4 = vecs[i].half; ph4 = 0; end
                else begin half8 = vecs[i].half; ph8 = 0; end
                repeat (5) step();
                if (vecs[i].sel4) begin en4 = 1'b1; ref4 = cyc; end
                else begin en8 = 1'b1; ref8 = cyc; end
            end else if (vecs[i].sel4 && half4 != vecs[i].half) begin
                half4 = vecs[i].half; ph4 = 0;
            end else if (!vecs[i].sel4 && half8 != vecs[i].half) begin
                half8 = vecs[i].half; ph8 = 0;
            end
            push(vecs[i].sel4, vecs[i].exp_freq, vecs[i].exp_ovf, vecs[i].tol, vecs[i].gap);
            wait_empty(vecs[i].sel4, 150);
        end
        en4 = 1'b0;

        // Abort at gate cycle 50: no result, previous value held, then a fresh full window
        en8 = 1'b1;
        repeat (51) step();
        en8 = 1'b0;
        repeat (40) step();
        cmp("abort_freq8", int'(freq8), 10, 0);
        cmp("abort_ovf8", int'(ovf8), 0, 0);
        en8 = 1'b1;
        ref8 = cyc;
        push(1'b0, 10, 1'b0, 0, 101);
        wait_empty(1'b0, 150);

        // Reset at gate cycle 60 of the following window
        repeat (60) step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_zero("midreset");
        end
        reset = 1'b1;
        ref8 = cyc;
        push(1'b0, 10, 1'b0, 1, 101);
        wait_empty(1'b0, 150);
        en8 = 1'b0;

        // Boundary A: rise lands in the last gate cycle and belongs to the closing window
        half8 = 0; sig8 = 1'b0;
        repeat (10) step();
        en8 = 1'b1;
        ref8 = cyc;
        push(1'b0, 1, 1'b0, 0, 101);
        push(1'b0, 0, 1'b0, 0, 100);
        repeat (98) step();
        sig8 = 1'b1;
        wait_empty(1'b0, 250);
        en8 = 1'b0;
        step();
        sig8 = 1'b0;
        repeat (10) step();

        // Boundary B: rise one cycle later opens the next window
        en8 = 1'b1;
        ref8 = cyc;
        push(1'b0, 0, 1'b0, 0, 101);
        push(1'b0, 1, 1'b0, 0, 100);
        repeat (99) step();
        sig8 = 1'b1;
        wait_empty(1'b0, 250);
        en8 = 1'b0;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
